f_fetch_unit: RTL
=================

Name: f_fetch_unit

Overview:
- Instruction-fetch stage of the five-stage pipeline; sits directly upstream of the F/D pipeline register.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers up to two fetched words in a 2-entry FIFO.
- Presents {instr, pc, valid} to the F/D register, which loads only when the hazard unit's stall is low. Honours redirects (branch/jump targets) from decode by flushing all younger fetches.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- ADDR_LO, 32'h0000_3000, lowest legal fetch address; used only with the optional feature.
- ADDR_HI, 32'h0000_6FFC, highest legal fetch address; used only with the optional feature.

Ports:
- clk  in  1  Rising-edge clock.
- reset  in  1  Asynchronous, active-low reset.
- stall  in  1  Hazard-unit stall. When high, the F/D register holds.
- redirect_valid  in  1  One-cycle pulse from decode. Asserted only after the delay slot has been accepted.
- redirect_pc  in  32  Redirect target.
- imem_req  out  1  Memory read request.
- imem_addr  out  32  Word address. Stable while imem_req is high and ack has not yet arrived.
- imem_rdata  in  32  Read data; valid when imem_ack is high.
- imem_ack  in  1  Completes the current request. May arrive in the same cycle imem_req rises.
- f_instr  out  32  FIFO head instruction; 0 (nop) when empty.
- f_pc  out  32  FIFO head PC; 0 when empty.
- f_valid  out  1  FIFO non-empty.
- f_adel  out  1  Fetch address error on the head entry. Tied 0 unless IFU_ADEL_EN is defined.

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC, state=IDLE, FIFO empty.
  - imem_req=0, imem_addr=0, f_instr=0, f_pc=0, f_valid=0, f_adel=0.
  - Takes effect immediately, including mid-request. Any in-flight ack after reset release is ignored because state is IDLE.
- consume = f_valid & ~stall. The head pops at the clock edge.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its result will be kept.
  - DROP: request outstanding; its result will be discarded.
- imem_req=1 in WAIT and DROP. imem_addr = req_addr register.
- Issue rule, evaluated at each edge: a new request starts (state becomes WAIT, req_addr<=pc, pc<=pc+4) when all of the following hold:
  - no request remains outstanding after the edge;
  - FIFO count after the edge (pushes and pops applied) plus 1 is ≤ 2.
- Issuing on the same edge as an ack is allowed. With ack every cycle and no stall, throughput is 1 instruction/cycle.
- IDLE:
  - Issue if the rule allows.
  - The first imem_req rises 1 cycle after reset deasserts. The first f_valid appears on the edge of the first ack.
- WAIT & ack:
  - Push {imem_rdata, req_addr} into the FIFO.
  - Then issue (stay WAIT) or go to IDLE.
- WAIT & ~ack: hold.
- Redirect (redirect_valid=1), highest priority:
  - FIFO flushed; a same-cycle pop and push are both discarded. f_valid=0 next cycle.
  - pc<=redirect_pc.
  - If in WAIT without ack: go to DROP; req_addr is unchanged.
  - If in WAIT with ack, or in IDLE: the data is discarded; issue redirect_pc immediately (req_addr<=redirect_pc, pc<=redirect_pc+4, state=WAIT).
- DROP & ack: discard the data; issue from pc per the issue rule.
- Redirect while in DROP: pc<=redirect_pc; stay DROP.
- FIFO invariant: count + (state==WAIT) ≤ 2. Overflow is impossible by construction; assert it in simulation.
- pc+4 wraps modulo 2^32.

Optional Feature:
- Macro: IFU_ADEL_EN.
- Defined, an address is illegal when any of these hold:
  - pc[1:0] != 0;
  - pc < ADDR_LO;
  - pc > ADDR_HI.
- Issuing an illegal address:
  - no memory request is made;
  - an entry {instr=0, pc, adel=1} is pushed directly on the issue edge;
  - pc advances normally.
- f_adel = head adel bit.
- Undefined: no check is made; f_adel is constant 0.

Decomposition:
- Shared package (cpu_defs):
  - RESET_PC default;
  - NOP_INSTR=32'h0;
  - fetch state encoding IDLE/WAIT/DROP;
  - legal address bounds.
- Sub-module f_fetch_fifo: 2-entry, width 65 bits {adel, pc, instr}, with push, pop and flush. Flush has priority over push and pop. Exposes count and head.

Test Plan:
- Reset release, ack same cycle as req, stall=0 → f_pc sequence 0x3000, 0x3004, 0x3008 on consecutive cycles; f_instr equals memory contents.
- Stall held for 4 cycles with ack always high → at most 2 entries buffered, imem_req drops, f_pc held. After release: no duplicate and no skipped PC.
- Request to 0x3010 with ack delayed 3 cycles, redirect to 0x3400 in cycle 1 → state goes to DROP, the 0x3010 word never appears, next f_pc=0x3400.
- Redirect on the same edge as ack and consume → FIFO empty next cycle; imem_addr=0x3400 issued on that edge; next f_pc=0x3400.
- reset=0 asserted while WAIT → all outputs 0 immediately. After release, the first imem_addr is 0x3000 and a stale ack is ignored.
- IFU_ADEL_EN defined, redirect to 0x3402 → no imem_req for that address; head {instr=0, pc=0x3402, f_adel=1}; then fetch continues at 0x3406 (also flagged).

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the fetch stage: reset PC, nop encoding,
// fetch FSM states, legal fetch window and the fetch queue entry.
package cpu_defs;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] ADDR_LO_DEF  = 32'h0000_3000;
  localparam logic [31:0] ADDR_HI_DEF  = 32'h0000_6FFC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fstate_e;

  typedef struct packed {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_ent_t;

  function automatic logic addr_illegal(
    input logic [31:0] a,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (a[1:0] != 2'b00) || (a < lo) || (a > hi);
  endfunction

endpackage

// File: rtl/f_fetch_fifo.sv
// Two-entry fetch queue. Flush beats push/pop; the insert lane
// lands after flush so an issue-edge error entry survives a redirect.
module f_fetch_fifo
  import cpu_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       pop_i,
  input  logic       push_i,
  input  fq_ent_t    push_data_i,
  input  logic       ins_i,
  input  fq_ent_t    ins_data_i,
  output logic [1:0] count_o,
  output fq_ent_t    head_o
);

  fq_ent_t    e0_q, e0_d;
  fq_ent_t    e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ovf;

  // next-state of the two slots and the occupancy count
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    ovf   = 1'b0;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      if (pop_i && cnt_d != 2'd0) begin
        e0_d  = e1_q;
        cnt_d = cnt_d - 2'd1;
      end
      if (push_i) begin
        unique case (cnt_d)
          2'd0: e0_d = push_data_i;
          2'd1: e1_d = push_data_i;
          default: ovf = 1'b1;
        endcase
        if (cnt_d != 2'd2) cnt_d = cnt_d + 2'd1;
      end
    end
    if (ins_i) begin
      unique case (cnt_d)
        2'd0: e0_d = ins_data_i;
        2'd1: e1_d = ins_data_i;
        default: ovf = 1'b1;
      endcase
      if (cnt_d != 2'd2) cnt_d = cnt_d + 2'd1;
    end
  end

  // queue storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = e0_q;

  a_no_ovf: assert property (
    @(posedge clk) disable iff (!rst_n) !ovf
  );

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage: owns the PC, issues imem reads, queues up to two words.
// Optional IFU_ADEL_EN flags out-of-window or misaligned fetches.
module f_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef IFU_ADEL_EN
  ,
  parameter logic [31:0] ADDR_LO  = ADDR_LO_DEF,
  parameter logic [31:0] ADDR_HI  = ADDR_HI_DEF
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc,
  output logic        f_valid,
  output logic        f_adel
);

  fstate_e     state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;

  logic [1:0]  cnt;
  fq_ent_t     head;
  fq_ent_t     push_data;
  fq_ent_t     ins_data;
  logic        busy;
  logic        outst;
  logic        push_mem;
  logic        pop;
  logic        issue;
  logic        ill;
  logic        ins;
  logic [2:0]  cnt_after;
  logic [31:0] base;

  assign busy     = (state_q != S_IDLE);
  assign f_valid  = (cnt != 2'd0);
  assign pop      = f_valid & ~stall;
  assign imem_req = busy;
  assign imem_addr = req_addr_q;

  assign push_data = '{adel: 1'b0,
                       pc: req_addr_q,
                       instr: imem_rdata};
  assign ins_data  = '{adel: 1'b1,
                       pc: base,
                       instr: NOP_INSTR};

  // issue decision and FSM next state
  always_comb begin
    push_mem = (state_q == S_WAIT) & imem_ack
             & ~redirect_valid;
    outst    = busy & ~imem_ack;
    if (redirect_valid)
      cnt_after = 3'd0;
    else
      cnt_after = {1'b0, cnt} + {2'b0, push_mem}
                - {2'b0, pop};
    issue = ~outst & (cnt_after < 3'd2);
    base  = redirect_valid ? redirect_pc : pc_q;
`ifdef IFU_ADEL_EN
    ill = addr_illegal(base, ADDR_LO, ADDR_HI);
`else
    ill = 1'b0;
`endif
    ins        = 1'b0;
    state_d    = state_q;
    pc_d       = base;
    req_addr_d = req_addr_q;
    if (issue) begin
      pc_d = base + 32'd4;
      if (ill) begin
        ins     = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d    = S_WAIT;
        req_addr_d = base;
      end
    end else if (outst) begin
      state_d = redirect_valid ? S_DROP : state_q;
    end else begin
      state_d = S_IDLE;
    end
  end

  // fetch FSM, PC and request address registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  f_fetch_fifo u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .flush_i     (redirect_valid),
    .pop_i       (pop),
    .push_i      (push_mem),
    .push_data_i (push_data),
    .ins_i       (ins),
    .ins_data_i  (ins_data),
    .count_o     (cnt),
    .head_o      (head)
  );

  assign f_instr = f_valid ? head.instr : NOP_INSTR;
  assign f_pc    = f_valid ? head.pc : 32'd0;
  assign f_adel  = f_valid & head.adel;

  a_inv: assert property (
    @(posedge clk) disable iff (!reset)
    ({1'b0, cnt} + {2'b0, state_q == S_WAIT}) <= 3'd2
  );

endmodule
